// File: rtl/nn_classifier_feeder_if.sv
// Bundle of the feeder's upstream handshake, register-write port and classifier-side bus.
// The master modport is the environment side; the feeder itself uses the slave modport.
interface nn_classifier_feeder_if #(
  parameter int DATA_W = 16
);
  logic              clear;
  logic              feat_valid;
  logic [DATA_W-1:0] feat_in;
  logic              feat_ready;
  logic              w_wr_en;
  logic [3:0]        w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              bias_wr_en;
  logic [DATA_W-1:0] bias_wr_data;
  logic              nn_classifier_en;
  logic [DATA_W-1:0] in_kiri_1;
  logic [DATA_W-1:0] in_atas;
  logic [DATA_W-1:0] b1;
  logic              busy;
  logic              done;

  modport master (
    output clear, feat_valid, feat_in, w_wr_en, w_wr_addr, w_wr_data,
           bias_wr_en, bias_wr_data,
    input  feat_ready, nn_classifier_en, in_kiri_1, in_atas, b1, busy, done
  );

  modport slave (
    input  clear, feat_valid, feat_in, w_wr_en, w_wr_addr, w_wr_data,
           bias_wr_en, bias_wr_data,
    output feat_ready, nn_classifier_en, in_kiri_1, in_atas, b1, busy, done
  );
endinterface

// File: rtl/nn_classifier_feeder.sv
// Buffers one feature vector, then replays feature/weight pairs, a bias beat and drain
// beats to nn_classifier with a contiguous enable window. All outputs are registered.
module nn_classifier_feeder #(
  parameter int DATA_W    = 16,
  parameter int N_FEAT    = 9,
  parameter int DRAIN_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  nn_classifier_feeder_if.slave bus
);

  localparam int CNT_W = $clog2(N_FEAT + DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_FEAT  = CNT_W'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    BIAS   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              feat_ready_q, feat_ready_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] kiri_q, kiri_d;
  logic [DATA_W-1:0] atas_q, atas_d;
  logic [DATA_W-1:0] b1_q, b1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] fbuf_q [N_FEAT];
  logic [DATA_W-1:0] w_q    [N_FEAT];
  logic [DATA_W-1:0] bias_q;

  logic feat_acc, w_we, b_we;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    feat_ready_d = 1'b0;
    en_d         = 1'b0;
    kiri_d       = '0;
    atas_d       = '0;
    b1_d         = '0;
    done_d       = 1'b0;
    feat_acc     = 1'b0;
    w_we         = 1'b0;
    b_we         = 1'b0;

    if (bus.clear) begin
      state_d      = LOAD;
      cnt_d        = '0;
      feat_ready_d = 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          feat_ready_d = 1'b1;
          w_we         = bus.w_wr_en && (int'(bus.w_wr_addr) < N_FEAT);
          b_we         = bus.bias_wr_en;
          if (bus.feat_valid && feat_ready_q) begin
            feat_acc = 1'b1;
            if (cnt_q == LAST_FEAT) begin
              cnt_d        = '0;
              state_d      = STREAM;
              feat_ready_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        STREAM: begin
          en_d   = 1'b1;
          kiri_d = fbuf_q[cnt_q];
          atas_d = w_q[cnt_q];
          if (cnt_q == LAST_FEAT) begin
            cnt_d   = '0;
            state_d = BIAS;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BIAS: begin
          en_d    = 1'b1;
          b1_d    = bias_q;
          cnt_d   = '0;
          state_d = DRAIN;
        end
        DRAIN: begin
          // One extra DRAIN visit produces the done cycle so en drops in the same beat done rises.
          if (cnt_q == DRAIN_LAST) begin
            done_d       = 1'b1;
            feat_ready_d = 1'b1;
            cnt_d        = '0;
            state_d      = LOAD;
          end else begin
            en_d  = 1'b1;
            b1_d  = bias_q;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      feat_ready_q <= 1'b0;
      en_q         <= 1'b0;
      kiri_q       <= '0;
      atas_q       <= '0;
      b1_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      feat_ready_q <= feat_ready_d;
      en_q         <= en_d;
      kiri_q       <= kiri_d;
      atas_q       <= atas_d;
      b1_q         <= b1_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_FEAT; i++) begin
        fbuf_q[i] <= '0;
        w_q[i]    <= '0;
      end
      bias_q <= '0;
    end else begin
      if (feat_acc) fbuf_q[cnt_q] <= bus.feat_in;
      if (w_we) w_q[bus.w_wr_addr] <= bus.w_wr_data;
      if (b_we) bias_q <= bus.bias_wr_data;
    end
  end

  assign bus.feat_ready       = feat_ready_q;
  assign bus.nn_classifier_en = en_q;
  assign bus.in_kiri_1        = kiri_q;
  assign bus.in_atas          = atas_q;
  assign bus.b1               = b1_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_nn_classifier_feeder.sv
// Directed bench for nn_classifier_feeder: a per-cycle vector table for the basic and
// backpressure flow, plus hand sequences for gaps, clear and asynchronous reset.
module tb_nn_classifier_feeder;

  localparam int DATA_W    = 16;
  localparam int N_FEAT    = 9;
  localparam int DRAIN_CYC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nn_classifier_feeder_if #(.DATA_W(DATA_W)) bus ();

  nn_classifier_feeder #(
    .DATA_W(DATA_W),
    .N_FEAT(N_FEAT),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {feat_ready, en, in_kiri_1, in_atas, b1, busy, done}
  typedef logic [51:0] obs_t;
  typedef logic [15:0] fvec_t [9];

  typedef struct {
    logic        fv;
    logic [15:0] fd;
    logic        wen;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        ben;
    logic [15:0] bd;
    logic        clr;
    obs_t        exp;
  } row_t;

  row_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic obs_t pk(input logic rdy, input logic en, input logic [15:0] k,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic bsy, input logic dn);
    return {rdy, en, k, a, b, bsy, dn};
  endfunction

  function automatic row_t mk(input logic fv, input logic [15:0] fd, input logic wen,
                              input logic [3:0] wa, input logic [15:0] wd, input logic ben,
                              input logic [15:0] bd, input logic clr, input obs_t exp);
    row_t r;
    r.fv = fv; r.fd = fd; r.wen = wen; r.wa = wa; r.wd = wd;
    r.ben = ben; r.bd = bd; r.clr = clr; r.exp = exp;
    return r;
  endfunction

  function automatic row_t idle(input obs_t exp);
    return mk(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0, exp);
  endfunction

  function automatic row_t feed(input logic [15:0] d, input obs_t exp);
    return mk(1'b1, d, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0, exp);
  endfunction

  task automatic chk(input string name, input obs_t exp);
    obs_t act;
    act = {bus.feat_ready, bus.nn_classifier_en, bus.in_kiri_1, bus.in_atas, bus.b1,
           bus.busy, bus.done};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got rdy=%b en=%b kiri=%h atas=%h b1=%h busy=%b done=%b, expected rdy=%b en=%b kiri=%h atas=%h b1=%h busy=%b done=%b",
                  name, act[51], act[50], act[49:34], act[33:18], act[17:2], act[1], act[0],
                  exp[51], exp[50], exp[49:34], exp[33:18], exp[17:2], exp[1], exp[0]);
  endtask

  // Drive at the falling edge, sample 1ns after the rising edge.
  task automatic cyc(input row_t r, input string name);
    @(negedge clk);
    bus.feat_valid   = r.fv;
    bus.feat_in      = r.fd;
    bus.w_wr_en      = r.wen;
    bus.w_wr_addr    = r.wa;
    bus.w_wr_data    = r.wd;
    bus.bias_wr_en   = r.ben;
    bus.bias_wr_data = r.bd;
    bus.clear        = r.clr;
    @(posedge clk);
    #1;
    chk(name, r.exp);
  endtask

  task automatic load_vec(input fvec_t f, input string tag);
    for (int k = 0; k < 9; k++)
      cyc(feed(f[k], pk(k < 8, 1'b0, 16'h0, 16'h0, 16'h0, k == 8, 1'b0)),
          $sformatf("%s_acc%0d", tag, k));
  endtask

  task automatic stream_chk(input fvec_t f, input logic [15:0] w, input logic [15:0] b,
                            input string tag);
    for (int k = 0; k < 9; k++)
      cyc(idle(pk(1'b0, 1'b1, f[k], w, 16'h0, 1'b1, 1'b0)), $sformatf("%s_beat%0d", tag, k));
    cyc(idle(pk(1'b0, 1'b1, 16'h0, 16'h0, b, 1'b1, 1'b0)), {tag, "_bias"});
    for (int k = 0; k < DRAIN_CYC; k++)
      cyc(idle(pk(1'b0, 1'b1, 16'h0, 16'h0, b, 1'b1, 1'b0)), $sformatf("%s_drain%0d", tag, k));
    cyc(idle(pk(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1)), {tag, "_done"});
  endtask

  initial begin
    fvec_t v1, v2, vg, vc, vd, ve, vr;
    obs_t  ld;
    v1 = '{16'h034C, 16'h064F, 16'h067D, 16'h048A, 16'h044F,
           16'h03C9, 16'h0563, 16'h04BA, 16'h069D};
    v2[0] = 16'h1111;
    for (int k = 1; k < 9; k++) v2[k] = 16'h2000 + 16'(k);
    for (int k = 0; k < 9; k++) begin
      vg[k] = 16'h0100 + 16'(k);
      vc[k] = 16'h0B00 + 16'(k);
      vd[k] = 16'h0D00 + 16'(k);
      ve[k] = 16'h0E00 + 16'(k);
      vr[k] = 16'h8C00 + 16'(k);
    end
    ld = pk(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Basic vector, backpressure and write protection, one row per clock.
    tbl.push_back(idle(ld));
    for (int k = 0; k < 9; k++)
      tbl.push_back(mk(1'b0, 16'h0, 1'b1, 4'(k), 16'h0001, k == 0, 16'hF3A3, 1'b0, ld));
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 4'd12, 16'h7FFF, 1'b0, 16'h0, 1'b0, ld));
    for (int k = 0; k < 9; k++)
      tbl.push_back(feed(v1[k], pk(k < 8, 1'b0, 16'h0, 16'h0, 16'h0, k == 8, 1'b0)));
    for (int k = 0; k < 9; k++)
      tbl.push_back(mk(1'b1, 16'h1111, k == 0, 4'd2, 16'h7FFF, 1'b0, 16'h0, 1'b0,
                       pk(1'b0, 1'b1, v1[k], 16'h0001, 16'h0, 1'b1, 1'b0)));
    tbl.push_back(feed(16'h1111, pk(1'b0, 1'b1, 16'h0, 16'h0, 16'hF3A3, 1'b1, 1'b0)));
    tbl.push_back(mk(1'b1, 16'h1111, 1'b0, 4'd0, 16'h0, 1'b1, 16'h0123, 1'b0,
                     pk(1'b0, 1'b1, 16'h0, 16'h0, 16'hF3A3, 1'b1, 1'b0)));
    tbl.push_back(feed(16'h1111, pk(1'b0, 1'b1, 16'h0, 16'h0, 16'hF3A3, 1'b1, 1'b0)));
    tbl.push_back(feed(16'h1111, pk(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1)));
    for (int k = 0; k < 9; k++)
      tbl.push_back(feed(v2[k], pk(k < 8, 1'b0, 16'h0, 16'h0, 16'h0, k == 8, 1'b0)));
    for (int k = 0; k < 9; k++)
      tbl.push_back(idle(pk(1'b0, 1'b1, v2[k], 16'h0001, 16'h0, 1'b1, 1'b0)));
    tbl.push_back(idle(pk(1'b0, 1'b1, 16'h0, 16'h0, 16'hF3A3, 1'b1, 1'b0)));
    tbl.push_back(idle(pk(1'b0, 1'b1, 16'h0, 16'h0, 16'hF3A3, 1'b1, 1'b0)));
    tbl.push_back(idle(pk(1'b0, 1'b1, 16'h0, 16'h0, 16'hF3A3, 1'b1, 1'b0)));
    tbl.push_back(idle(pk(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1)));
    tbl.push_back(idle(ld));

    rst = 1'b1;
    bus.clear = 1'b0; bus.feat_valid = 1'b0; bus.feat_in = '0;
    bus.w_wr_en = 1'b0; bus.w_wr_addr = '0; bus.w_wr_data = '0;
    bus.bias_wr_en = 1'b0; bus.bias_wr_data = '0;
    #12;
    chk("reset_state", '0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) cyc(tbl[i], $sformatf("row%0d", i));

    // Gapped upstream: idle cycles carry junk data that must not be stored.
    for (int k = 0; k < 9; k++) begin
      cyc(feed(vg[k], pk(k < 8, 1'b0, 16'h0, 16'h0, 16'h0, k == 8, 1'b0)),
          $sformatf("gap_acc%0d", k));
      if (k < 8)
        cyc(mk(1'b0, 16'hDEAD, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0, ld),
            $sformatf("gap_idle%0d", k));
    end
    stream_chk(vg, 16'h0001, 16'hF3A3, "gap");

    // Clear after 5 features; clear outranks a same-cycle feature and register writes.
    for (int k = 0; k < 5; k++) cyc(feed(16'h0AA0 + 16'(k), ld), $sformatf("clr_part%0d", k));
    cyc(mk(1'b1, 16'h0FFF, 1'b1, 4'd0, 16'h5555, 1'b1, 16'h6666, 1'b1, ld), "clr_load");
    load_vec(vc, "clr");
    stream_chk(vc, 16'h0001, 16'hF3A3, "clr");

    // Clear while the FSM sits in BIAS: enable and bias drop, no done follows.
    load_vec(vd, "cb");
    for (int k = 0; k < 9; k++)
      cyc(idle(pk(1'b0, 1'b1, vd[k], 16'h0001, 16'h0, 1'b1, 1'b0)), $sformatf("cb_beat%0d", k));
    cyc(mk(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b1, ld), "cb_clear");
    for (int k = 0; k < 4; k++) cyc(idle(ld), $sformatf("cb_nodone%0d", k));

    // Asynchronous reset between edges mid-STREAM wipes weights and bias too.
    load_vec(ve, "ar");
    for (int k = 0; k < 3; k++)
      cyc(idle(pk(1'b0, 1'b1, ve[k], 16'h0001, 16'h0, 1'b1, 1'b0)), $sformatf("ar_beat%0d", k));
    #2;
    rst = 1'b1;
    #1;
    chk("ar_async_zero", '0);
    @(negedge clk);
    rst = 1'b0;
    cyc(idle(ld), "ar_release");
    load_vec(vr, "ar2");
    stream_chk(vr, 16'h0000, 16'h0000, "ar2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
